// File: rtl/bram_op_pkg.sv
// Shared types and encodings for the BRAM operator sequencer.
package bram_op_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [3:0] OP_CS_ADD  = 4'b0001;
  localparam logic [3:0] OP_CS_SUB  = 4'b0010;
  localparam logic [3:0] OP_CS_MUL  = 4'b0100;
  localparam logic [3:0] OP_CS_COPY = 4'b1000;

  localparam logic [1:0] OP_MODE_ADD = 2'd0;
  localparam logic [1:0] OP_MODE_SUB = 2'd1;
  localparam logic [1:0] OP_MODE_MUL = 2'd2;

  function automatic logic op_cs_legal(input logic [3:0] op_cs);
    case (op_cs)
      OP_CS_ADD, OP_CS_SUB, OP_CS_MUL, OP_CS_COPY: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Copy never drives the operator, so it shares the add encoding.
  function automatic logic [1:0] op_mode_of(input logic [3:0] op_cs);
    case (op_cs)
      OP_CS_SUB: return OP_MODE_SUB;
      OP_CS_MUL: return OP_MODE_MUL;
      default:   return OP_MODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/bram_op_sequencer_addr_gen.sv
// Loadable wrap-around address and beat counter; one instance per address stream.
module bram_op_addr_gen
  import bram_op_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  at_len,
  output logic                  at_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (clr) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= base;
      cnt   <= '0;
      len_q <= len;
    end else if (step) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

  assign at_len  = (cnt == len_q);
  // at_last lets the owner act on the final beat without waiting a cycle.
  assign at_last = ((cnt + 1'b1) == len_q);

endmodule

// File: rtl/bram_op_sequencer.sv
// Streams word pairs from two BRAMs through an external operator (or copies)
// and writes results back to a selectable BRAM, bounded by a credit window.
module bram_op_sequencer
  import bram_op_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int DEPTH           = 64,
  parameter int ADDR_WIDTH      = $clog2(DEPTH),
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  start,
  input  logic [3:0]            op_cs,
  input  logic                  dst_sel,
  input  logic [ADDR_WIDTH-1:0] src0_addr,
  input  logic [ADDR_WIDTH-1:0] src1_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  bram0_rd_en,
  output logic                  bram1_rd_en,
  output logic [ADDR_WIDTH-1:0] bram0_rd_addr,
  output logic [ADDR_WIDTH-1:0] bram1_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram0_dout,
  input  logic [DATA_WIDTH-1:0] bram1_dout,
  output logic                  bram0_we,
  output logic                  bram1_we,
  output logic [ADDR_WIDTH-1:0] bram0_wr_addr,
  output logic [ADDR_WIDTH-1:0] bram1_wr_addr,
  output logic [DATA_WIDTH-1:0] bram0_din,
  output logic [DATA_WIDTH-1:0] bram1_din,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [1:0]            op_mode,
  output logic                  op_in_valid,
  input  logic [DATA_WIDTH-1:0] op_res,
  input  logic                  op_res_valid
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  state_t                  state;
  logic                    is_copy;
  logic                    dst_sel_q;
  logic                    err_q;
  logic                    rd_q;
  logic [OUT_W-1:0]        outstanding;

  logic                    load;
  logic                    clr;
  logic                    active;
  logic                    rd_issue;
  logic                    rd_done;
  logic                    rd_last;
  logic                    res_valid;
  logic [DATA_WIDTH-1:0]   res_data;
  logic                    wb_now;
  logic                    wr_done;
  logic                    wr_last;
  logic [ADDR_WIDTH-1:0]   dst_cur;
  logic                    src0_at_len, src0_at_last;
  logic                    src1_at_len, src1_at_last;

  assign clr    = !init_calib_complete;
  assign load   = (state == ST_IDLE) && start;
  assign active = (state == ST_ISSUE) || (state == ST_DRAIN);

  assign rd_done  = src0_at_len && src1_at_len;
  assign rd_last  = src0_at_last && src1_at_last;
  assign rd_issue = (state == ST_ISSUE) && !rd_done && (outstanding < OUT_MAX);

  assign bram0_rd_en = rd_issue;
  assign bram1_rd_en = rd_issue && !is_copy;

  // Copy turns the bram0 read beat itself into the result stream.
  assign res_valid = is_copy ? rd_q : op_res_valid;
  assign res_data  = is_copy ? bram0_dout : op_res;
  assign wb_now    = active && res_valid && !wr_done;

  assign op_a = op_in_valid ? bram0_dout : '0;
  assign op_b = op_in_valid ? bram1_dout : '0;

  bram_op_addr_gen #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_src0_gen (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .step(rd_issue),
    .base(src0_addr), .len(len), .addr(bram0_rd_addr),
    .at_len(src0_at_len), .at_last(src0_at_last)
  );

  bram_op_addr_gen #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_src1_gen (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .step(rd_issue),
    .base(src1_addr), .len(len), .addr(bram1_rd_addr),
    .at_len(src1_at_len), .at_last(src1_at_last)
  );

  bram_op_addr_gen #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_dst_gen (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .step(wb_now),
    .base(dst_addr), .len(len), .addr(dst_cur),
    .at_len(wr_done), .at_last(wr_last)
  );

  // DONE is entered with the last write so the pulse lands one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      is_copy       <= 1'b0;
      dst_sel_q     <= 1'b0;
      err_q         <= 1'b0;
      rd_q          <= 1'b0;
      outstanding   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      op_mode       <= OP_MODE_ADD;
      op_in_valid   <= 1'b0;
      bram0_we      <= 1'b0;
      bram1_we      <= 1'b0;
      bram0_wr_addr <= '0;
      bram1_wr_addr <= '0;
      bram0_din     <= '0;
      bram1_din     <= '0;
    end else if (!init_calib_complete) begin
      state         <= ST_IDLE;
      is_copy       <= 1'b0;
      dst_sel_q     <= 1'b0;
      err_q         <= 1'b0;
      rd_q          <= 1'b0;
      outstanding   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      op_mode       <= OP_MODE_ADD;
      op_in_valid   <= 1'b0;
      bram0_we      <= 1'b0;
      bram1_we      <= 1'b0;
      bram0_wr_addr <= '0;
      bram1_wr_addr <= '0;
      bram0_din     <= '0;
      bram1_din     <= '0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      rd_q        <= rd_issue;
      op_in_valid <= rd_issue && !is_copy;
      bram0_we    <= wb_now && !dst_sel_q;
      bram1_we    <= wb_now && dst_sel_q;

      if (wb_now && !dst_sel_q) begin
        bram0_din     <= res_data;
        bram0_wr_addr <= dst_cur;
      end
      if (wb_now && dst_sel_q) begin
        bram1_din     <= res_data;
        bram1_wr_addr <= dst_cur;
      end

      case ({rd_issue, wb_now})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            is_copy   <= (op_cs == OP_CS_COPY);
            dst_sel_q <= dst_sel;
            op_mode   <= op_mode_of(op_cs);
            err_q     <= !op_cs_legal(op_cs);
            if (!op_cs_legal(op_cs) || (len == '0)) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (rd_issue && rd_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wb_now && wr_last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= err_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_op_sequencer.sv
// Scoreboard bench: BRAM and operator models feed the sequencer, expected writes are queued at start.
`timescale 1ns/1ps
module tb_bram_op_sequencer;

  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int MAXO  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_calib_complete;
  logic          start;
  logic [3:0]    op_cs;
  logic          dst_sel;
  logic [AW-1:0] src0_addr, src1_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done, err;
  logic          bram0_rd_en, bram1_rd_en;
  logic [AW-1:0] bram0_rd_addr, bram1_rd_addr;
  logic [DW-1:0] bram0_dout, bram1_dout;
  logic          bram0_we, bram1_we;
  logic [AW-1:0] bram0_wr_addr, bram1_wr_addr;
  logic [DW-1:0] bram0_din, bram1_din;
  logic [DW-1:0] op_a, op_b;
  logic [1:0]    op_mode;
  logic          op_in_valid;
  logic [DW-1:0] op_res;
  logic          op_res_valid;

  always #5 clk = ~clk;

  bram_op_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .start(start),
    .op_cs(op_cs), .dst_sel(dst_sel), .src0_addr(src0_addr), .src1_addr(src1_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .bram0_rd_en(bram0_rd_en), .bram1_rd_en(bram1_rd_en),
    .bram0_rd_addr(bram0_rd_addr), .bram1_rd_addr(bram1_rd_addr),
    .bram0_dout(bram0_dout), .bram1_dout(bram1_dout),
    .bram0_we(bram0_we), .bram1_we(bram1_we),
    .bram0_wr_addr(bram0_wr_addr), .bram1_wr_addr(bram1_wr_addr),
    .bram0_din(bram0_din), .bram1_din(bram1_din),
    .op_a(op_a), .op_b(op_b), .op_mode(op_mode), .op_in_valid(op_in_valid),
    .op_res(op_res), .op_res_valid(op_res_valid)
  );

  // BRAM pair: one-cycle read latency, read-before-write, plus a bench fill port.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] q0, q1;
  logic          fill_en = 1'b0;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_d0, fill_d1;

  always @(posedge clk) begin
    if (bram0_rd_en) q0 <= mem0[bram0_rd_addr];
    if (bram1_rd_en) q1 <= mem1[bram1_rd_addr];
    if (fill_en) begin
      mem0[fill_addr] <= fill_d0;
      mem1[fill_addr] <= fill_d1;
    end
    if (bram0_we) mem0[bram0_wr_addr] <= bram0_din;
    if (bram1_we) mem1[bram1_wr_addr] <= bram1_din;
  end
  assign bram0_dout = q0;
  assign bram1_dout = q1;

  // Operator model with programmable latency and an injector for stray result beats.
  int            lat = 1;
  logic [15:0]   pv = '0;
  logic [DW-1:0] pd [16];
  logic          inject = 1'b0;
  logic [DW-1:0] inject_data = '0;

  function automatic logic [DW-1:0] opCompute(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (m)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[14:0], op_in_valid};
    pd[0] <= opCompute(op_mode, op_a, op_b);
    for (int i = 1; i < 16; i++) pd[i] <= pd[i-1];
  end
  assign op_res_valid = pv[lat-1] | inject;
  assign op_res       = inject ? inject_data : pd[lat-1];

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q [$];
  logic [AW-1:0] rdaddr_q [$];
  wr_t           mon_e;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  int   cyc = 0;
  int   rd0_cnt, rd1_cnt, iv_cnt, we_cnt, outst, max_outst, first_we_cyc, last_we_cyc;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples on the falling edge, retiring scoreboard entries per write.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (bram0_rd_en) begin
        rd0_cnt++;
        if (rdaddr_q.size() > 0) checkOutput("rd_addr", bram0_rd_addr, rdaddr_q.pop_front());
      end
      if (bram1_rd_en) rd1_cnt++;
      if (op_in_valid) iv_cnt++;
      if (bram0_we || bram1_we) begin
        checkOutput("we_onehot", bram0_we & bram1_we, 0);
        if (we_cnt == 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        we_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("we_unexpected", {bram1_we, bram0_we}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wr_port", bram1_we, mon_e.port);
          checkOutput("wr_addr", bram1_we ? bram1_wr_addr : bram0_wr_addr, mon_e.addr);
          checkOutput("wr_data", bram1_we ? bram1_din : bram0_din, mon_e.data);
        end
      end
      outst = rd0_cnt - we_cnt;
      if (outst > max_outst) max_outst = outst;
    end
  end

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  int   start_cyc, done_at;
  logic got_done, err_at;

  task automatic clearCounters();
    rd0_cnt = 0; rd1_cnt = 0; iv_cnt = 0; we_cnt = 0;
    outst = 0; max_outst = 0; first_we_cyc = 0; last_we_cyc = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] cs, input logic ds, input int s0, input int s1,
                               input int d, input int n, input int l);
    wr_t           e;
    logic [DW-1:0] a, b;
    @(posedge clk); #1;
    lat = l;
    if (cs inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
      for (int i = 0; i < n; i++) begin
        a = mem0[(s0 + i) % DEPTH];
        b = mem1[(s1 + i) % DEPTH];
        case (cs)
          4'b0001: e.data = a + b;
          4'b0010: e.data = a - b;
          4'b0100: e.data = a * b;
          default: e.data = a;
        endcase
        e.port = ds;
        e.addr = AW'((d + i) % DEPTH);
        exp_q.push_back(e);
      end
    end
    clearCounters();
    op_cs = cs; dst_sel = ds;
    src0_addr = AW'(s0); src1_addr = AW'(s1); dst_addr = AW'(d);
    len = (AW + 1)'(n);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitDone(input int limit);
    got_done = 1'b0;
    err_at   = 1'b0;
    done_at  = 0;
    for (int i = 0; i < limit && !got_done; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        done_at  = cyc;
        err_at   = err;
      end
    end
    checkOutput("done_seen", got_done, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; init_calib_complete = 1'b0; start = 1'b0;
    op_cs = '0; dst_sel = 1'b0; src0_addr = '0; src1_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      fill_en = 1'b1; fill_addr = AW'(i);
      fill_d0 = randWord(); fill_d1 = randWord();
    end
    @(posedge clk); #1;
    fill_en = 1'b0;

    checkOutput("rst_ctrl", {busy, done, err, bram0_rd_en, bram1_rd_en, bram0_we, bram1_we, op_in_valid}, 0);
    checkOutput("rst_op_a", op_a, 0);
    checkOutput("rst_opmode_addr", {op_mode, bram0_rd_addr, bram1_wr_addr}, 0);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    init_calib_complete = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] add len=8 L=1");
    applyStimulus(4'b0001, 1'b0, 0, 16, 32, 8, 1);
    waitDone(200);
    checkOutput("add_done_lat", done_at - start_cyc, 12);
    checkOutput("add_err", err_at, 0);
    checkOutput("add_we_cnt", we_cnt, 8);
    checkOutput("add_we_span", last_we_cyc - first_we_cyc, 7);
    checkOutput("add_q_empty", exp_q.size(), 0);
    for (int i = 0; i < 8; i += 3) checkOutput("add_mem", mem0[32 + i], mem0[i] + mem1[16 + i]);

    $display("[TB] mul len=10 L=6 to bram1");
    applyStimulus(4'b0100, 1'b1, 20, 40, 5, 10, 6);
    waitDone(300);
    checkOutput("mul_max_outst", max_outst, MAXO);
    checkOutput("mul_we_cnt", we_cnt, 10);
    checkOutput("mul_err", err_at, 0);
    checkOutput("mul_q_empty", exp_q.size(), 0);

    $display("[TB] sub len=5 L=2 full rate");
    applyStimulus(4'b0010, 1'b0, 50, 10, 45, 5, 2);
    waitDone(200);
    checkOutput("sub_done_lat", done_at - start_cyc, 10);
    checkOutput("sub_we_cnt", we_cnt, 5);
    checkOutput("sub_q_empty", exp_q.size(), 0);

    $display("[TB] copy with source wrap");
    for (int i = 0; i < 8; i++) rdaddr_q.push_back(AW'((60 + i) % DEPTH));
    applyStimulus(4'b1000, 1'b1, 60, 0, 2, 8, 1);
    waitDone(200);
    checkOutput("copy_done_lat", done_at - start_cyc, 11);
    checkOutput("copy_in_valid", iv_cnt, 0);
    checkOutput("copy_rd1", rd1_cnt, 0);
    checkOutput("copy_rd0", rd0_cnt, 8);
    checkOutput("copy_rdaddr_left", rdaddr_q.size(), 0);
    checkOutput("copy_q_empty", exp_q.size(), 0);
    checkOutput("copy_mem_wrap", mem1[6], mem0[0]);

    $display("[TB] illegal op_cs");
    applyStimulus(4'b0011, 1'b0, 0, 0, 0, 4, 1);
    waitDone(50);
    checkOutput("ill_done_lat", done_at - start_cyc, 2);
    checkOutput("ill_err", err_at, 1);
    checkOutput("ill_access", rd0_cnt + rd1_cnt + we_cnt, 0);

    $display("[TB] len zero");
    applyStimulus(4'b0001, 1'b0, 0, 0, 0, 0, 1);
    waitDone(50);
    checkOutput("len0_done_lat", done_at - start_cyc, 2);
    checkOutput("len0_err", err_at, 0);
    checkOutput("len0_access", rd0_cnt + rd1_cnt + we_cnt, 0);

    $display("[TB] reset mid-command");
    applyStimulus(4'b0001, 1'b0, 0, 0, 20, 20, 1);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_ctrl", {busy, done, err, bram0_rd_en, bram1_rd_en, bram0_we, bram1_we, op_in_valid}, 0);
    checkOutput("midrst_din", bram0_din, 0);
    checkOutput("midrst_op_a", op_a, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clearCounters();
    inject = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inject_data = randWord();
      @(posedge clk); #1;
    end
    inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stale_no_we", we_cnt, 0);

    applyStimulus(4'b0001, 1'b0, 0, 0, 20, 20, 1);
    waitDone(300);
    checkOutput("post_rst_done_lat", done_at - start_cyc, 24);
    checkOutput("post_rst_we_cnt", we_cnt, 20);
    checkOutput("post_rst_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
